// File: rtl/gs_fetch.sv
// Instruction fetch stage: drives a 1-cycle-latency instruction SRAM, buffers
// returned words in a 2-entry FIFO and hands them to decode with a valid/ready handshake.
module gs_fetch #(
  parameter logic [31:0] BOOT_ADDR = 32'h0,
  parameter int          ADDR_SIZE = 32,
  parameter int          WORD_SIZE = 32,
  parameter int          BYTES     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 im_cs,
  output logic                 im_oe,
  output logic [BYTES-1:0]     im_web,
  output logic [13:0]          im_addr,
  input  logic [WORD_SIZE-1:0] im_do,
  input  logic                 redirect_valid,
  input  logic [ADDR_SIZE-1:0] redirect_pc,
  output logic                 if_valid,
  output logic [WORD_SIZE-1:0] if_instr,
  output logic [ADDR_SIZE-1:0] if_pc,
  input  logic                 id_ready
);

  typedef struct packed {
    logic [WORD_SIZE-1:0] instr;
    logic [ADDR_SIZE-1:0] pc;
  } entry_t;

  logic [ADDR_SIZE-1:0] pc;
  logic [ADDR_SIZE-1:0] inflight_pc;
  logic                 inflight;
  logic                 kill;
  entry_t               fifo_mem [2];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           count;

  logic                 pop;
  logic                 push;
  logic                 issue;
  logic [2:0]           credit_used;

  // Slots already committed: buffered entries plus the read whose data is arriving,
  // minus the entry leaving this cycle. Keeping this below 2 makes overflow impossible.
  assign pop         = if_valid & id_ready;
  assign credit_used = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue       = rst & ~redirect_valid & (credit_used < 3'd2);
  assign push        = inflight & ~kill & ~redirect_valid;

  assign im_cs    = rst;
  assign im_oe    = issue;
  assign im_web   = '1;
  assign im_addr  = pc[15:2];

  assign if_valid = (count != 2'd0);
  assign if_instr = fifo_mem[rd_ptr].instr;
  assign if_pc    = fifo_mem[rd_ptr].pc;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values of its peers regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc       <= ADDR_SIZE'(BOOT_ADDR);
      inflight <= 1'b0;
      kill     <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      inflight <= issue;
      if (redirect_valid) begin
        // Redirect wins over everything: realign target, drop buffered and pending words.
        pc     <= redirect_pc & ~ADDR_SIZE'(3);
        kill   <= 1'b1;
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (issue) begin
          pc   <= pc + ADDR_SIZE'(4);
          kill <= 1'b0;
        end
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        if (push && !pop)      count <= count + 2'd1;
        else if (pop && !push) count <= count - 2'd1;
      end
    end
  end

  // NOTE: FIFO storage and the in-flight PC carry no reset; count/inflight gate
  // their use, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (issue) inflight_pc <= pc;
    if (push)  fifo_mem[wr_ptr] <= '{instr: im_do, pc: inflight_pc};
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst)
    (push && !pop) |-> (count != 2'd2));

endmodule

// File: tb/tb_gs_fetch.sv
// Directed table-driven bench for gs_fetch: boot, backpressure, redirects,
// address wrap and mid-stream reset, against a word-k = 0x1000+k SRAM model.
module tb_gs_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_cs;
  logic        im_oe;
  logic [3:0]  im_web;
  logic [13:0] im_addr;
  logic [31:0] im_do;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          chk;
    bit          rst;
    bit          rv;
    logic [31:0] rpc;
    bit          rdy;
    bit          ev;
    logic [31:0] epc;
    bit          eoe;
    logic [31:0] eipc;
  } vec_t;

  vec_t vecs[$];

  gs_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .im_cs          (im_cs),
    .im_oe          (im_oe),
    .im_web         (im_web),
    .im_addr        (im_addr),
    .im_do          (im_do),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, word k holds 0x1000 + k.
  always @(posedge clk) if (im_oe) im_do <= 32'h1000 + {18'b0, im_addr};

  function automatic logic [31:0] exp_instr(logic [31:0] pc);
    return 32'h1000 + {18'b0, pc[15:2]};
  endfunction

  function automatic vec_t mk(bit chk, bit r, bit rv, logic [31:0] rpc, bit rdy,
                              bit ev, logic [31:0] epc, bit eoe, logic [31:0] eipc);
    vec_t v;
    v.chk = chk; v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.eoe = eoe; v.eipc = eipc;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v, string tag, int idx);
    string n;
    rst            = v.rst;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    id_ready       = v.rdy;
    #4;
    n = $sformatf("%s[%0d]", tag, idx);
    if (v.chk) begin
      check({n, " im_cs"}, 64'(im_cs), 64'(v.rst));
      check({n, " im_web"}, 64'(im_web), 64'hF);
      check({n, " if_valid"}, 64'(if_valid), 64'(v.ev));
      if (v.ev) begin
        check({n, " if_pc"}, 64'(if_pc), 64'(v.epc));
        check({n, " if_instr"}, 64'(if_instr), 64'(exp_instr(v.epc)));
      end
      check({n, " im_oe"}, 64'(im_oe), 64'(v.eoe));
      if (v.eoe) check({n, " im_addr"}, 64'(im_addr), 64'(v.eipc[15:2]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(string tag);
    apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 0), tag, -2);
    apply(mk(1, 0, 0, 0, 1, 0, 0, 0, 0), tag, -1);
  endtask

  // Common prologue after reset: issue 0, 4, 8 with decode ready.
  task automatic boot3(string tag);
    apply(mk(1, 1, 0, 0, 1, 0, 0, 1, 32'h0), tag, 0);
    apply(mk(1, 1, 0, 0, 1, 0, 0, 1, 32'h4), tag, 1);
    apply(mk(1, 1, 0, 0, 1, 1, 32'h0, 1, 32'h8), tag, 2);
  endtask

  initial begin
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;

    // Boot stream: first valid in cycle 2, then one instruction per cycle.
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0,      1, 32'h0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0,      1, 32'h4));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h0,  1, 32'h8));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h4,  1, 32'hC));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h8,  1, 32'h10));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'hC,  1, 32'h14));
    // Redirect to 0x40 while the read of 0x8 is in flight.
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,     1, 0, 0,      1, 32'h0));
    vecs.push_back(mk(1, 1, 0, 0,     1, 0, 0,      1, 32'h4));
    vecs.push_back(mk(1, 1, 0, 0,     1, 1, 32'h0,  1, 32'h8));
    vecs.push_back(mk(1, 1, 1, 32'h40, 1, 1, 32'h4, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,     1, 0, 0,      1, 32'h40));
    vecs.push_back(mk(1, 1, 0, 0,     1, 0, 0,      1, 32'h44));
    vecs.push_back(mk(1, 1, 0, 0,     1, 1, 32'h40, 1, 32'h48));
    vecs.push_back(mk(1, 1, 0, 0,     1, 1, 32'h44, 1, 32'h4C));
    // Backpressure: decode stalls 5 cycles after the first instruction.
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0,     1, 32'h0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0,     1, 32'h4));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 1, 0, 0, 0, 1, 32'h0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h0, 1, 32'h8));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h4, 1, 32'hC));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h8, 1, 32'h10));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'hC, 1, 32'h14));

    #1;
    foreach (vecs[i]) apply(vecs[i], "table", i);

    // Misaligned redirect followed immediately by another: the last one wins.
    do_reset("b2b");
    boot3("b2b");
    apply(mk(1, 1, 1, 32'h43, 1, 1, 32'h4, 0, 0), "b2b", 3);
    apply(mk(1, 1, 1, 32'h80, 1, 0, 0,     0, 0), "b2b", 4);
    apply(mk(1, 1, 0, 0,      1, 0, 0,     1, 32'h80), "b2b", 5);
    apply(mk(1, 1, 0, 0,      1, 0, 0,     1, 32'h84), "b2b", 6);
    apply(mk(1, 1, 0, 0,      1, 1, 32'h80, 1, 32'h88), "b2b", 7);
    apply(mk(1, 1, 0, 0,      1, 1, 32'h84, 1, 32'h8C), "b2b", 8);

    // PC wraps from the top of the address space back to zero.
    do_reset("wrap");
    boot3("wrap");
    apply(mk(1, 1, 1, 32'hFFFF_FFFC, 1, 1, 32'h4, 0, 0), "wrap", 3);
    apply(mk(1, 1, 0, 0, 1, 0, 0,              1, 32'hFFFF_FFFC), "wrap", 4);
    apply(mk(1, 1, 0, 0, 1, 0, 0,              1, 32'h0), "wrap", 5);
    apply(mk(1, 1, 0, 0, 1, 1, 32'hFFFF_FFFC,  1, 32'h4), "wrap", 6);
    apply(mk(1, 1, 0, 0, 1, 1, 32'h0,          1, 32'h8), "wrap", 7);
    apply(mk(1, 1, 0, 0, 1, 1, 32'h4,          1, 32'hC), "wrap", 8);

    // Reset with the FIFO full, then again with a read in flight.
    do_reset("mrst");
    apply(mk(1, 1, 0, 0, 1, 0, 0,     1, 32'h0), "mrst", 0);
    apply(mk(1, 1, 0, 0, 1, 0, 0,     1, 32'h4), "mrst", 1);
    apply(mk(1, 1, 0, 0, 0, 1, 32'h0, 0, 0),     "mrst", 2);
    apply(mk(1, 1, 0, 0, 0, 1, 32'h0, 0, 0),     "mrst", 3);
    apply(mk(1, 0, 0, 0, 0, 1, 32'h0, 0, 0),     "mrst", 4);
    apply(mk(1, 1, 0, 0, 1, 0, 0,     1, 32'h0), "mrst", 5);
    apply(mk(1, 1, 0, 0, 1, 0, 0,     1, 32'h4), "mrst", 6);
    apply(mk(1, 1, 0, 0, 1, 1, 32'h0, 1, 32'h8), "mrst", 7);
    apply(mk(1, 1, 0, 0, 1, 1, 32'h4, 1, 32'hC), "mrst", 8);
    apply(mk(1, 0, 0, 0, 1, 1, 32'h8, 0, 0),     "mrst", 9);
    apply(mk(1, 1, 0, 0, 1, 0, 0,     1, 32'h0), "mrst", 10);
    apply(mk(1, 1, 0, 0, 1, 0, 0,     1, 32'h4), "mrst", 11);
    apply(mk(1, 1, 0, 0, 1, 1, 32'h0, 1, 32'h8), "mrst", 12);
    apply(mk(1, 1, 0, 0, 1, 1, 32'h4, 1, 32'hC), "mrst", 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
